// File: rtl/rgb_hue_pwm.sv
// N-channel hue-wheel PWM generator: a trapezoidal colour wheel swept across
// NUM_CH LED channels with programmable resolution, speed, polarity and direction.
module rgb_hue_pwm #(
  parameter int PWM_BITS         = 8,
  parameter int PERIODS_PER_STEP = 16,
  parameter int NUM_CH           = 3,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              dir,
  output logic [NUM_CH-1:0]                 led,
  output logic [$clog2(2*NUM_CH)-1:0]       seg,
  output logic                              wrap
);

  localparam int B    = PWM_BITS;
  localparam int SEGS = 2 * NUM_CH;
  localparam int SW   = $clog2(SEGS);
  localparam int PW   = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;

  localparam logic [B-1:0]  MAX      = {B{1'b1}};
  localparam logic [B:0]    FULL     = {1'b1, {B{1'b0}}};
  localparam logic [PW-1:0] PER_LAST = PW'(PERIODS_PER_STEP - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(SEGS - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  logic [B-1:0]  pwm_cnt;
  logic [PW-1:0] per_cnt;
  logic [B-1:0]  step;
  logic [B:0]    duty_q [NUM_CH];
  logic [B:0]    duty_d [NUM_CH];

  logic period_end;
  logic step_ev;
  logic step_wrap;
  logic seg_wrap;

  // Trapezoid profile indexed by the channel's position r relative to seg.
  function automatic logic [B:0] duty_of(input int r, input logic [B-1:0] s);
    if (r == 0 || r == SEGS - 1) return FULL;
    else if (r == 1)             return FULL - {1'b0, s};
    else if (r == SEGS - 2)      return {1'b0, s};
    else                         return '0;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      duty_d[c] = duty_of((int'(seg) + SEGS - 2 * c) % SEGS, step);
    end
  end

  assign period_end = en && (pwm_cnt == MAX);
  assign step_ev    = period_end && (per_cnt == PER_LAST);
  assign step_wrap  = dir ? (step == '0) : (step == MAX);
  assign seg_wrap   = step_ev && step_wrap && (dir ? (seg == '0) : (seg == SEG_LAST));

  // NOTE: every register here, including the small duty_q shadow array, is
  // explicitly reset so the first period after reset is deterministic duty 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      per_cnt <= '0;
      step    <= '0;
      seg     <= '0;
      wrap    <= 1'b0;
      duty_q  <= '{default: '0};
      led     <= {NUM_CH{POL}};
    end else begin
      wrap <= seg_wrap;
      if (en) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          led[c] <= ({1'b0, pwm_cnt} < duty_q[c]) ^ POL;
        end
        // Shadow latch at period end keeps the duty constant within a period.
        if (period_end) begin
          duty_q  <= duty_d;
          per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
        end
        if (step_ev) begin
          step <= dir ? step - 1'b1 : step + 1'b1;
          if (step_wrap) begin
            if (dir) seg <= (seg == '0) ? SEG_LAST : seg - 1'b1;
            else     seg <= (seg == SEG_LAST) ? '0 : seg + 1'b1;
          end
        end
      end else begin
        led <= {NUM_CH{POL}};
      end
    end
  end

endmodule
